mod_updown_counter: RTL

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Up/down counter with limit MAX_VAL, wrap or saturate at the limits,
// clamped parallel load, registered terminal-count pulse and sticky ovf/unf flags.
module mod_updown_counter #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter int          SATURATE = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             u_d,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] load_clamped;
  logic             ovf_evt, unf_evt;

  assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

  // Events only exist on a counting step; load masks them.
  assign ovf_evt = !load && en &&  u_d && (count_q == MAX_W);
  assign unf_evt = !load && en && !u_d && (count_q == ZERO);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (u_d) begin
        if (ovf_evt) count_d = SAT ? MAX_W : ZERO;
        else         count_d = count_q + ONE;
      end else begin
        if (unf_evt) count_d = SAT ? ZERO : MAX_W;
        else         count_d = count_q - ONE;
      end
    end
  end

  // A new event beats a coincident clear.
  always_comb begin
    tc_d  = ovf_evt | unf_evt;
    ovf_d = ovf_evt | (ovf_q & ~clr_flags);
    unf_d = unf_evt | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
